// File: rtl/peripheral_dbg_burst_master_apb4.sv
// rtl/peripheral_dbg_burst_master_apb4.sv - debug command to Wishbone burst master (optional watchdog: PERIPHERAL_DBG_BURST_MASTER_TIMEOUT_EN)
module peripheral_dbg_burst_master_apb4 #(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             apb4_clk_i,
    input  logic             apb4_rstn_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [AW-1:0]    cmd_adr_i,
    input  logic             cmd_we_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [1:0]       cmd_bte_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic             wdata_valid_i,
    input  logic [DW-1:0]    wdata_i,
    output logic             wdata_ready_o,
    output logic             rdata_valid_o,
    output logic [DW-1:0]    rdata_o,
    output logic             done_o,
    output logic             err_o,
    output logic [AW-1:0]    apb4_adr_o,
    output logic [DW-1:0]    apb4_dat_o,
    output logic [3:0]       apb4_sel_o,
    output logic             apb4_we_o,
    output logic [1:0]       apb4_bte_o,
    output logic [2:0]       apb4_cti_o,
    output logic             apb4_cyc_o,
    output logic             apb4_stb_o,
    input  logic [DW-1:0]    apb4_dat_i,
    input  logic             apb4_ack_i,
    input  logic             apb4_err_i,
    input  logic             apb4_rty_i
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      adr_q, adr_d;
    logic [DW-1:0]      dat_q, dat_d;
    logic [3:0]         sel_q, sel_d;
    logic               we_q, we_d;
    logic [1:0]         bte_q, bte_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               single_q, single_d;
    logic               held_q, held_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;

    logic               stb;
    logic               timeout;
    logic               bus_err;
    logic               beat_ack;
    logic               last_beat;
    logic               wr_take;
    logic [AW-3:0]      idx;
    logic [AW-3:0]      idx_inc;
    logic [AW-3:0]      wrap_mask;
    logic [AW-3:0]      idx_next;

    // Command address is word aligned; the byte offset bits carry no information.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^cmd_adr_i[1:0];

    // A write beat is only presented once its data word is held in apb4_dat_o.
    assign stb       = (state_q == S_RUN) && (!we_q || held_q);
    assign bus_err   = (stb && (apb4_err_i || apb4_rty_i)) || timeout;
    assign beat_ack  = stb && apb4_ack_i && !bus_err;
    assign last_beat = (cnt_q == '0);
    assign wr_take   = (state_q == S_RUN) && we_q && !held_q && wdata_valid_i;

`ifdef PERIPHERAL_DBG_BURST_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Watchdog counts strobe cycles without a slave response; any response restarts it.
    always_comb begin
        to_cnt_d = '0;
        timeout  = 1'b0;
        if (stb && !apb4_ack_i && !apb4_err_i && !apb4_rty_i) begin
            to_cnt_d = to_cnt_q + 1'b1;
            timeout  = (to_cnt_d == TW'(TIMEOUT_CYCLES));
        end
    end

    // Watchdog counter register.
    always_ff @(posedge apb4_clk_i or negedge apb4_rstn_i) begin
        if (!apb4_rstn_i) to_cnt_q <= '0;
        else              to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    // Next word index: the wrap mask limits which index bits may carry.
    always_comb begin
        idx     = adr_q[AW-1:2];
        idx_inc = idx + 1'b1;
        case (bte_q)
            2'b01:   wrap_mask = (AW-2)'(3);
            2'b10:   wrap_mask = (AW-2)'(7);
            2'b11:   wrap_mask = (AW-2)'(15);
            default: wrap_mask = '1;
        endcase
        idx_next = (idx & ~wrap_mask) | (idx_inc & wrap_mask);
    end

    // Next-state and datapath updates for the command FSM.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        bte_d    = bte_q;
        cnt_d    = cnt_q;
        single_d = single_q;
        held_d   = held_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    adr_d    = {cmd_adr_i[AW-1:2], 2'b00};
                    we_d     = cmd_we_i;
                    sel_d    = cmd_sel_i;
                    bte_d    = cmd_bte_i;
                    cnt_d    = cmd_len_i;
                    single_d = (cmd_len_i == '0);
                    held_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (wr_take) begin
                    dat_d  = wdata_i;
                    held_d = 1'b1;
                end
                if (bus_err) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (beat_ack) begin
                    held_d = 1'b0;
                    adr_d  = {idx_next, 2'b00};
                    if (!we_q) begin
                        rdata_d  = apb4_dat_i;
                        rvalid_d = 1'b1;
                    end
                    if (last_beat) state_d = S_DONE;
                    else           cnt_d   = cnt_q - 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge apb4_clk_i or negedge apb4_rstn_i) begin
        if (!apb4_rstn_i) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            bte_q    <= '0;
            cnt_q    <= '0;
            single_q <= 1'b0;
            held_q   <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            bte_q    <= bte_d;
            cnt_q    <= cnt_d;
            single_q <= single_d;
            held_q   <= held_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign wdata_ready_o = wr_take;
    assign rdata_valid_o = rvalid_q;
    assign rdata_o       = rdata_q;
    assign err_o         = err_q;
    assign apb4_cyc_o    = (state_q == S_RUN);
    assign apb4_stb_o    = stb;
    assign apb4_adr_o    = adr_q;
    assign apb4_dat_o    = dat_q;
    assign apb4_sel_o    = sel_q;
    assign apb4_we_o     = we_q;
    assign apb4_bte_o    = bte_q;
    assign apb4_cti_o    = ((state_q == S_RUN) && !single_q) ? (last_beat ? 3'b111 : 3'b010) : 3'b000;

endmodule

// File: tb/tb_peripheral_dbg_burst_master_apb4.sv
// tb/tb_peripheral_dbg_burst_master_apb4.sv - directed self-checking bench for the debug burst master
module tb_peripheral_dbg_burst_master_apb4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_adr = '0;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_len = '0;
    logic [1:0]  cmd_bte = '0;
    logic [3:0]  cmd_sel = 4'hF;
    logic        wdata_valid = 1'b0;
    logic [31:0] wdata = '0;
    logic        wdata_ready;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic [31:0] bus_adr;
    logic [31:0] bus_dat_o;
    logic [3:0]  bus_sel;
    logic        bus_we;
    logic [1:0]  bus_bte;
    logic [2:0]  bus_cti;
    logic        bus_cyc;
    logic        bus_stb;
    logic [31:0] bus_dat_i = '0;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic        bus_rty = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023];
    int          slave_mode = 0;   // 0 normal, 1 never responds, 2 ack and err together
    logic [31:0] log_adr [$];
    logic [2:0]  log_cti [$];
    logic [31:0] log_rd  [$];
    int          n_wready, n_done, n_gap, n_stb;
    logic        err_at_done, cyc_at_done, rdy_at_done;
    logic [31:0] wq [0:15];

    always #5 clk = ~clk;

    peripheral_dbg_burst_master_apb4 #(.DW(32), .AW(32), .LEN_W(4), .TIMEOUT_CYCLES(8)) dut (
        .apb4_clk_i(clk), .apb4_rstn_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_adr_i(cmd_adr),
        .cmd_we_i(cmd_we), .cmd_len_i(cmd_len), .cmd_bte_i(cmd_bte), .cmd_sel_i(cmd_sel),
        .wdata_valid_i(wdata_valid), .wdata_i(wdata), .wdata_ready_o(wdata_ready),
        .rdata_valid_o(rdata_valid), .rdata_o(rdata), .done_o(done), .err_o(err),
        .apb4_adr_o(bus_adr), .apb4_dat_o(bus_dat_o), .apb4_sel_o(bus_sel), .apb4_we_o(bus_we),
        .apb4_bte_o(bus_bte), .apb4_cti_o(bus_cti), .apb4_cyc_o(bus_cyc), .apb4_stb_o(bus_stb),
        .apb4_dat_i(bus_dat_i), .apb4_ack_i(bus_ack), .apb4_err_i(bus_err), .apb4_rty_i(bus_rty)
    );

    // Slave RAM model and bus monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_dat_i = '0;
        if (rst_n && bus_cyc && bus_stb) begin
            n_stb++;
            if (slave_mode == 1) begin
            end else if (bus_adr < 32'h1000) begin
                bus_ack   = 1'b1;
                bus_err   = (slave_mode == 2);
                bus_dat_i = mem[bus_adr[11:2]];
                log_adr.push_back(bus_adr);
                log_cti.push_back(bus_cti);
                if (bus_we && slave_mode == 0)
                    for (int b = 0; b < 4; b++)
                        if (bus_sel[b]) mem[bus_adr[11:2]][8*b +: 8] = bus_dat_o[8*b +: 8];
            end else begin
                bus_err = 1'b1;
            end
        end
        if (bus_cyc && !bus_stb) n_gap++;
        if (rdata_valid) log_rd.push_back(rdata);
        if (wdata_ready) n_wready++;
        if (done) begin
            n_done++;
            err_at_done = err;
            cyc_at_done = bus_cyc;
            rdy_at_done = cmd_ready;
        end
    end

    task automatic clear_logs();
        log_adr.delete();
        log_cti.delete();
        log_rd.delete();
        n_wready = 0; n_done = 0; n_gap = 0; n_stb = 0;
        err_at_done = 1'bx; cyc_at_done = 1'bx; rdy_at_done = 1'bx;
    endtask

    task automatic feed(input int len, input int gap_beat, input int gap_cycles);
        for (int i = 0; i <= len; i++) begin
            int t;
            if (i == gap_beat) begin
                wdata_valid = 1'b0;
                repeat (gap_cycles) @(posedge clk);
                #1;
            end
            wdata_valid = 1'b1;
            wdata = wq[i];
            t = 0;
            do begin @(negedge clk); t++; end while (!wdata_ready && t < 100);
            @(posedge clk); #1;
            if (t >= 100) break;
        end
        wdata_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 300);
        checks++;
        if (!done) begin errors++; $display("FAIL done_timeout: done_o=%0b after %0d cycles, required 1", done, t); end
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input logic [31:0] adr, input logic we, input logic [3:0] len,
                           input logic [1:0] bte, input int gap_beat, input int gap_cycles);
        clear_logs();
        fork
            begin
                cmd_adr = adr; cmd_we = we; cmd_len = len; cmd_bte = bte; cmd_sel = 4'hF;
                cmd_valid = 1'b1;
                @(posedge clk); #1;
                cmd_valid = 1'b0;
            end
            begin if (we) feed(int'(len), gap_beat, gap_cycles); end
            wait_done();
        join
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({bus_cyc, bus_stb, bus_we} !== 3'b000) begin errors++; $display("FAIL reset_cyc_stb_we: got %b required 000", {bus_cyc, bus_stb, bus_we}); end
        checks++; if ({done, err, rdata_valid, wdata_ready} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b required 0000", {done, err, rdata_valid, wdata_ready}); end
        checks++; if (bus_cti !== 3'b000 || bus_adr !== 32'h0 || bus_dat_o !== 32'h0 || rdata !== 32'h0) begin errors++; $display("FAIL reset_bus: cti=%b adr=%h dat=%h rdata=%h required all zero", bus_cti, bus_adr, bus_dat_o, rdata); end
        checks++; if (bus_sel !== 4'h0 || bus_bte !== 2'b00) begin errors++; $display("FAIL reset_sel_bte: sel=%h bte=%b required 0", bus_sel, bus_bte); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        run_cmd(32'h100, 1'b0, 4'd0, 2'b00, -1, 0);
        checks++; if (log_adr.size() != 1 || log_adr[0] !== 32'h100) begin errors++; $display("FAIL single_adr: beats=%0d adr=%h required 1 beat at 00000100", log_adr.size(), log_adr[0]); end
        checks++; if (log_cti[0] !== 3'b000) begin errors++; $display("FAIL single_cti: got %b required 000", log_cti[0]); end
        checks++; if (log_rd.size() != 1 || log_rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: strobes=%0d data=%h required 1 of deadbeef", log_rd.size(), log_rd[0]); end
        checks++; if (n_done != 1 || cyc_at_done !== 1'b0 || rdy_at_done !== 1'b0) begin errors++; $display("FAIL single_done: done=%0d cyc=%b ready=%b required 1,0,0", n_done, cyc_at_done, rdy_at_done); end
    endtask

    task automatic test_burst_write();
        logic [2:0] ecti [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
        for (int i = 0; i < 4; i++) wq[i] = 32'(i + 1);
        run_cmd(32'h200, 1'b1, 4'd3, 2'b00, -1, 0);
        checks++; if (log_adr.size() != 4) begin errors++; $display("FAIL wr_beats: got %0d required 4", log_adr.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (log_adr[i] !== 32'h200 + 32'(4*i) || log_cti[i] !== ecti[i]) begin errors++; $display("FAIL wr_beat%0d: adr=%h cti=%b required %h %b", i, log_adr[i], log_cti[i], 32'h200 + 32'(4*i), ecti[i]); end
            checks++; if (mem[128 + i] !== 32'(i + 1)) begin errors++; $display("FAIL wr_mem%0d: got %h required %h", i, mem[128 + i], i + 1); end
        end
        checks++; if (n_wready != 4 || n_done != 1) begin errors++; $display("FAIL wr_counts: wready=%0d done=%0d required 4,1", n_wready, n_done); end
    endtask

    task automatic test_wrap_read(input logic [31:0] adr, input logic [1:0] bte, input logic [31:0] e0,
                                  input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] ea [4];
        ea = '{e0, e1, e2, e3};
        run_cmd(adr, 1'b0, 4'd3, bte, -1, 0);
        checks++; if (log_adr.size() != 4 || log_rd.size() != 4) begin errors++; $display("FAIL wrap%0d_counts: beats=%0d strobes=%0d required 4,4", bte, log_adr.size(), log_rd.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (log_adr[i] !== ea[i] || log_rd[i] !== (32'hA5000000 | (ea[i] >> 2))) begin errors++; $display("FAIL wrap%0d_beat%0d: adr=%h data=%h required %h %h", bte, i, log_adr[i], log_rd[i], ea[i], 32'hA5000000 | (ea[i] >> 2)); end
        end
        checks++; if (log_cti[3] !== 3'b111 || bus_bte !== bte) begin errors++; $display("FAIL wrap%0d_cti_bte: cti=%b bte=%b required 111 %b", bte, log_cti[3], bus_bte, bte); end
    endtask

    task automatic test_write_gap();
        wq[0] = 32'h11112222; wq[1] = 32'h33334444;
        run_cmd(32'h300, 1'b1, 4'd1, 2'b00, 1, 5);
        checks++; if (n_gap < 5 || n_done != 1) begin errors++; $display("FAIL gap_wait: stb-low cycles=%0d done=%0d required >=5,1", n_gap, n_done); end
        checks++; if (mem[192] !== 32'h11112222 || mem[193] !== 32'h33334444) begin errors++; $display("FAIL gap_mem: got %h %h required 11112222 33334444", mem[192], mem[193]); end
        checks++; if (n_wready != 2 || log_adr.size() != 2) begin errors++; $display("FAIL gap_beats: wready=%0d beats=%0d required 2,2", n_wready, log_adr.size()); end
    endtask

    task automatic test_bus_error();
        run_cmd(32'h0010_0000, 1'b0, 4'd0, 2'b00, -1, 0);
        checks++; if (err_at_done !== 1'b1 || log_rd.size() != 0 || n_done != 1) begin errors++; $display("FAIL buserr: err=%b strobes=%0d done=%0d required 1,0,1", err_at_done, log_rd.size(), n_done); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL buserr_sticky: got %b required 1", err); end
        @(posedge clk); #1;
        run_cmd(32'h100, 1'b0, 4'd0, 2'b00, -1, 0);
        checks++; if (err_at_done !== 1'b0 || log_rd.size() != 1) begin errors++; $display("FAIL buserr_clear: err=%b strobes=%0d required 0,1", err_at_done, log_rd.size()); end
    endtask

    task automatic test_ack_err_same();
        slave_mode = 2;
        run_cmd(32'h0, 1'b0, 4'd1, 2'b00, -1, 0);
        slave_mode = 0;
        checks++; if (err_at_done !== 1'b1 || log_rd.size() != 0 || log_adr.size() != 1) begin errors++; $display("FAIL ackerr: err=%b strobes=%0d beats=%0d required 1,0,1", err_at_done, log_rd.size(), log_adr.size()); end
    endtask

`ifdef PERIPHERAL_DBG_BURST_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        slave_mode = 1;
        run_cmd(32'h100, 1'b0, 4'd0, 2'b00, -1, 0);
        slave_mode = 0;
        checks++; if (n_stb != 8 || err_at_done !== 1'b1 || n_done != 1) begin errors++; $display("FAIL timeout: stb cycles=%0d err=%b done=%0d required 8,1,1", n_stb, err_at_done, n_done); end
    endtask
`endif

    task automatic test_reset_mid_burst();
        int t = 0;
        slave_mode = 1;
        clear_logs();
        cmd_adr = 32'h100; cmd_we = 1'b0; cmd_len = 4'd3; cmd_bte = 2'b00; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        do begin @(negedge clk); t++; end while (!bus_stb && t < 20);
        checks++; if (bus_cyc !== 1'b1 || bus_stb !== 1'b1) begin errors++; $display("FAIL midrst_active: cyc=%b stb=%b required 1,1", bus_cyc, bus_stb); end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0) begin errors++; $display("FAIL midrst_drop: cyc=%b stb=%b required 0,0", bus_cyc, bus_stb); end
        slave_mode = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || bus_cyc !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_idle: ready=%b cyc=%b err=%b required 1,0,0", cmd_ready, bus_cyc, err); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 | 32'(i);
        mem[64] = 32'hDEADBEEF;
        clear_logs();
        test_reset();
        test_single_read();
        test_burst_write();
        test_wrap_read(32'h038, 2'b01, 32'h038, 32'h03C, 32'h030, 32'h034);
        test_wrap_read(32'h01C, 2'b10, 32'h01C, 32'h000, 32'h004, 32'h008);
        test_write_gap();
        test_bus_error();
        test_ack_err_same();
`ifdef PERIPHERAL_DBG_BURST_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
